// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_pkg;

    // Default requester count used when the top is instantiated without overrides.
    localparam int RR_N_DEFAULT = 4;

    // Widest one-hot vector onehot_to_idx can encode.
    localparam int RR_IDX_MAX_W = 32;

    typedef enum logic [0:0] {
        RR_IDLE,
        RR_GRANT
    } rr_state_t;

    // Binary index of the set bit in a one-hot vector. The set-bit indices are
    // OR-ed together, so an all-zero input gives index 0.
    function automatic int unsigned onehot_to_idx(input logic [RR_IDX_MAX_W-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < RR_IDX_MAX_W; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_masked_pick.sv
// Combinational round-robin pick: thermometer mask above the last winner,
// lowest set bit of the masked requests, or of all requests on wrap-around.
// Supports N up to rr_pkg::RR_IDX_MAX_W requesters.
module rr_masked_pick
    import rr_pkg::*;
#(
    parameter int N    = RR_N_DEFAULT,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] winner,
    output logic            any_req
);

    logic [N-1:0]            mask;
    logic [N-1:0]            masked;
    logic [N-1:0]            masked_low;
    logic [N-1:0]            req_low;
    logic [N-1:0]            choose;
    logic [RR_IDX_MAX_W-1:0] choose_wide;

    // Build the mask, isolate the lowest set bits and encode the winner.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(ptr)) begin
                mask[i] = 1'b1;
            end
        end
        masked      = req & mask;
        // x & -x keeps only the lowest set bit of x.
        masked_low  = masked & (~masked + N'(1));
        req_low     = req & (~req + N'(1));
        choose      = (|masked) ? masked_low : req_low;
        choose_wide = '0;
        choose_wide[N-1:0] = choose;
        winner      = ID_W'(onehot_to_idx(choose_wide));
        any_req     = |req;
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: picks a winner among N requesters, registers
// a one-hot grant and holds it until the owner pulses done or drops its request.
// Optional hold-timeout feature: define RR_HOLD_TIMEOUT_EN to force a release
// after HOLD_MAX grant cycles and pulse timeout; without it timeout is tied to 0.
module rr_grant_ctrl
    import rr_pkg::*;
#(
    parameter int N        = RR_N_DEFAULT,
    parameter int HOLD_MAX = 16,
    parameter int ID_W     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            timeout
);

    if (N < 2) begin : g_bad_n
        $error("rr_grant_ctrl: N must be at least 2");
    end
    if (HOLD_MAX < 2) begin : g_bad_hold
        $error("rr_grant_ctrl: HOLD_MAX must be at least 2");
    end

    rr_state_t       state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            any_req;
    logic            release_now;
    logic            force_rel;

    rr_masked_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    // Natural release: owner done, or owner no longer requesting.
    assign release_now = done | ~req[grant_id];

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX);

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;

    // Forced release only when the limit is reached and the owner has not let go.
    assign force_rel = (state == RR_GRANT) && !release_now &&
                       (hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign timeout   = timeout_q;

    // Count grant cycles; anything other than an ongoing hold clears the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if ((state == RR_GRANT) && !release_now && !force_rel) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Grant FSM: issue a registered one-hot grant from IDLE, hold it in GRANT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RR_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= ID_W'(N - 1);
        end else begin
            case (state)
                RR_IDLE: begin
                    if (any_req) begin
                        grant       <= {{(N-1){1'b0}}, 1'b1} << winner;
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                        ptr         <= winner;
                        state       <= RR_GRANT;
                    end
                end
                RR_GRANT: begin
                    if (release_now || force_rel) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        state       <= RR_IDLE;
                    end
                end
                default: begin
                    state <= RR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (N=4, HOLD_MAX=4). Each vector drives
// rst/req/done for one clock edge and lists the outputs expected after it.
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic       r;
        logic [3:0] q;
        logic       d;
        logic [3:0] g;
        logic [1:0] id;
        logic       t;
    } vec_t;

    rr_grant_ctrl #(
        .N        (4),
        .HOLD_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        vec_t vq[$];
        vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0});
        foreach (vq[i]) begin
            rst = vq[i].r; req = vq[i].q; done = vq[i].d;
            @(posedge clk); #1;
            vectors++;
            if ({grant, grant_valid, grant_id, timeout} !== {vq[i].g, (vq[i].g != 4'b0000), vq[i].id, vq[i].t}) begin
                $display("FAIL reset[%0d] got grant=%b valid=%b id=%0d timeout=%b, want grant=%b id=%0d timeout=%b",
                         i, grant, grant_valid, grant_id, timeout, vq[i].g, vq[i].id, vq[i].t);
                miscompares++;
            end
        end
    endtask

    task automatic test_rotation();
        vec_t vq[$];
        // Enters with grant 0001 active; done pulsed the cycle after each grant.
        vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        foreach (vq[i]) begin
            rst = vq[i].r; req = vq[i].q; done = vq[i].d;
            @(posedge clk); #1;
            vectors++;
            if ({grant, grant_valid, grant_id, timeout} !== {vq[i].g, (vq[i].g != 4'b0000), vq[i].id, vq[i].t}) begin
                $display("FAIL rotation[%0d] got grant=%b valid=%b id=%0d timeout=%b, want grant=%b id=%0d timeout=%b",
                         i, grant, grant_valid, grant_id, timeout, vq[i].g, vq[i].id, vq[i].t);
                miscompares++;
            end
        end
    endtask

    task automatic test_wrap_mask();
        vec_t vq[$];
        // Enters idle with last winner 0.
        vq.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0}); // winner 2
        vq.push_back('{1'b1, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0}); // done + drop together
        vq.push_back('{1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0}); // nothing above 2 -> wrap to 0
        vq.push_back('{1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0}); // req[0] dropped
        vq.push_back('{1'b1, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0}); // ptr=0 -> bit 1
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0}); // req[1] dropped
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0}); // ptr=1 -> wrap to 0
        foreach (vq[i]) begin
            rst = vq[i].r; req = vq[i].q; done = vq[i].d;
            @(posedge clk); #1;
            vectors++;
            if ({grant, grant_valid, grant_id, timeout} !== {vq[i].g, (vq[i].g != 4'b0000), vq[i].id, vq[i].t}) begin
                $display("FAIL wrap_mask[%0d] got grant=%b valid=%b id=%0d timeout=%b, want grant=%b id=%0d timeout=%b",
                         i, grant, grant_valid, grant_id, timeout, vq[i].g, vq[i].id, vq[i].t);
                miscompares++;
            end
        end
    endtask

    task automatic test_req_drop();
        vec_t vq[$];
        // Enters with grant 0001 active, last winner 0.
        vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0});
        vq.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0}); // held
        vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0}); // drop releases
        vq.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0}); // done in IDLE ignored
        vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0}); // single requester re-wins
        vq.push_back('{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0}); // other reqs ignored
        vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        foreach (vq[i]) begin
            rst = vq[i].r; req = vq[i].q; done = vq[i].d;
            @(posedge clk); #1;
            vectors++;
            if ({grant, grant_valid, grant_id, timeout} !== {vq[i].g, (vq[i].g != 4'b0000), vq[i].id, vq[i].t}) begin
                $display("FAIL req_drop[%0d] got grant=%b valid=%b id=%0d timeout=%b, want grant=%b id=%0d timeout=%b",
                         i, grant, grant_valid, grant_id, timeout, vq[i].g, vq[i].id, vq[i].t);
                miscompares++;
            end
        end
    endtask

    task automatic test_timeout();
        vec_t vq[$];
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0}); // grant edge
`ifdef RR_HOLD_TIMEOUT_EN
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0}); // 4th held cycle
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0, 1'b1}); // forced release
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0}); // re-grant
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0}); // done at limit wins
`else
        for (int k = 0; k < 24; k++) begin
            vq.push_back('{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0});
        end
        vq.push_back('{1'b1, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0});
`endif
        vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        foreach (vq[i]) begin
            rst = vq[i].r; req = vq[i].q; done = vq[i].d;
            @(posedge clk); #1;
            vectors++;
            if ({grant, grant_valid, grant_id, timeout} !== {vq[i].g, (vq[i].g != 4'b0000), vq[i].id, vq[i].t}) begin
                $display("FAIL timeout[%0d] got grant=%b valid=%b id=%0d timeout=%b, want grant=%b id=%0d timeout=%b",
                         i, grant, grant_valid, grant_id, timeout, vq[i].g, vq[i].id, vq[i].t);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        vec_t vq[$];
        // Enters idle with last winner 0.
        vq.push_back('{1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0});
        vq.push_back('{1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0}); // reset mid-grant
        vq.push_back('{1'b1, 4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        // Leave ptr at 1, then reset: ptr must return to 3 so bit 1 beats bit 2.
        vq.push_back('{1'b1, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0});
        vq.push_back('{1'b0, 4'b0110, 1'b0, 4'b0000, 2'd0, 1'b0});
        vq.push_back('{1'b1, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b0});
        foreach (vq[i]) begin
            rst = vq[i].r; req = vq[i].q; done = vq[i].d;
            @(posedge clk); #1;
            vectors++;
            if ({grant, grant_valid, grant_id, timeout} !== {vq[i].g, (vq[i].g != 4'b0000), vq[i].id, vq[i].t}) begin
                $display("FAIL reset_mid_grant[%0d] got grant=%b valid=%b id=%0d timeout=%b, want grant=%b id=%0d timeout=%b",
                         i, grant, grant_valid, grant_id, timeout, vq[i].g, vq[i].id, vq[i].t);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        req         = 4'b0000;
        done        = 1'b0;
        test_reset();
        test_rotation();
        test_wrap_mask();
        test_req_drop();
        test_timeout();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin grant controller that shares one resource among N requesters.
- Arbitrates with a thermometer priority mask built from the last winner, then registers and holds a one-hot grant until the owner releases it.
- Sits between requester ports and the shared datapath; the datapath consumes grant/grant_id, and the owner signals completion with done.

Parameters:
N, 4, number of requesters (>=2)
HOLD_MAX, 16, max cycles a grant may be held when the timeout feature is compiled in (>=2)
ID_W, $clog2(N), width of grant_id (derived; do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-low
req  input  N  request vector, level-sensitive, bit i = requester i
done  input  1  one-cycle release pulse from current owner
grant  output  N  registered one-hot grant, all-zero when idle
grant_valid  output  1  registered, equals |grant
grant_id  output  ID_W  registered binary index of granted requester, 0 when idle
timeout  output  1  one-cycle pulse on forced release; constant 0 without feature

Behaviour:
- Reset, sampled on an edge with rst=0, regardless of state:
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - FSM=IDLE, ptr=N-1, hold counter=0.
- ptr is the index of the last winner. Reset value N-1 makes requester 0 highest priority first.
- Pick logic (combinational):
  - mask = bits strictly above ptr (thermometer: ones at positions ptr+1..N-1).
  - masked = req & mask.
  - If masked != 0, winner = lowest set bit of masked; else winner = lowest set bit of req (wrap-around).
  - ptr=N-1 gives an all-zero mask, so the winner is the lowest set bit of req.
- FSM has two states: IDLE, GRANT.
- IDLE:
  - If |req on edge k: grant=onehot(winner), grant_id=winner, grant_valid=1, ptr<=winner, counter<=0, go to GRANT. Grant is visible after edge k (1-cycle latency).
  - If req=0: stay in IDLE. done is ignored.
- GRANT:
  - grant, grant_id and ptr are frozen. Changes on other req bits are ignored.
  - Release condition: done=1 or req[grant_id]=0. Both true in the same cycle counts as a single release.
  - On a release edge: grant=0, grant_valid=0, grant_id=0, go to IDLE.
  - At least one idle cycle always separates consecutive grants, even when the same requester re-requests.
- A grant never changes owner without first passing through all-zero.
- Reset mid-GRANT: grant drops on the reset edge, ptr returns to N-1, and no release/timeout pulse is generated.

Optional Feature:
Macro RR_HOLD_TIMEOUT_EN.
- Defined:
  - Hold counter (width $clog2(HOLD_MAX)) increments every GRANT cycle without a release.
  - When counter==HOLD_MAX-1 and no release that cycle, force a release: grant cleared, timeout=1 for exactly that one cycle after the edge, go to IDLE. Grant is therefore held at most HOLD_MAX cycles.
  - A natural release in the same cycle as the limit takes precedence; timeout stays 0.
- Undefined: no counter logic; timeout tied to 0; a grant is held indefinitely until done or request drop.

Decomposition:
- Shared package rr_pkg:
  - typedef enum logic [0:0] {RR_IDLE, RR_GRANT} rr_state_t
  - function onehot_to_idx
  - localparam default N.
- One natural sub-module, rr_masked_pick: purely combinational (req, ptr -> winner idx, any_req). Implements the thermometer mask plus two lowest-set-bit finders.
- FSM, registers and counter stay in rr_grant_ctrl.

Test Plan:
1. Reset:
   - rst=0 for 3 edges with req=4'b1111 -> grant=0000, grant_valid=0, grant_id=0, timeout=0.
   - Release rst=1 -> grant=0001, grant_id=0 one edge later.
2. Rotation: req=1111 held, done pulsed the cycle after each grant -> grants 0001,0010,0100,1000,0001 in order, each separated by exactly one all-zero cycle.
3. Wrap masking:
   - Last winner 2, then req=0011 -> grant 0001.
   - Next req=1010 (ptr=0) -> grant 0010.
   - Next req=0001 (ptr=1) -> grant 0001.
4. Request-drop release:
   - Grant 0100 active, req drops to 0000 -> grant=0000 next edge.
   - done pulsed during IDLE -> no effect.
   - New req=0100 later -> grant 0100 (single requester re-wins).
5. Timeout, with RR_HOLD_TIMEOUT_EN and HOLD_MAX=4: req=0001 held, done never asserted -> grant held exactly 4 cycles, timeout=1 for 1 cycle as grant drops, re-grant 0001 after the idle cycle. Without the macro: grant held 20+ cycles, timeout=0.
6. Reset mid-grant: grant=1000 active, rst=0 for one edge -> grant=0000, timeout=0. Then req=1001 -> grant 0001 (ptr back to N-1).
